// File: rtl/fpga250_cfg_pkg.sv
// Shared configuration-loader definitions for the fpga250 tile fabric.
// Holds the per-track bit budget and the loader FSM state encoding.
package fpga250_cfg_pkg;

   localparam int CFG_BITS_PER_TRACK = 6;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_SHIFT = 2'd1,
      CFG_FULL  = 2'd2
   } cfg_state_e;

   function automatic int cfg_width(input int tracks);
      return tracks * CFG_BITS_PER_TRACK;
   endfunction

endpackage

// File: rtl/switch_box_config_loader_counter.sv
// Saturating bit counter for the configuration loader.
// Counts accepted shifts up to MAX and holds there; clear wins over increment.
module cfg_bit_counter #(
   parameter int MAX = 48,
   localparam int CNTW = $clog2(MAX + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc,
   input  logic            clr,
   output logic [CNTW-1:0] count,
   output logic            full
);

   assign full = (count == CNTW'(MAX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !full) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/switch_box_config_loader.sv
// Serial configuration loader for one switch box: shifts a frame in, passes it
// down the daisy chain, and atomically commits a complete frame to c.
module switch_box_config_loader
   import fpga250_cfg_pkg::*;
#(
   parameter int W = 8,
   localparam int CW = W * CFG_BITS_PER_TRACK
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_en,
   input  logic          cfg_in,
   input  logic          cfg_commit,
   output logic          cfg_out,
   output logic [CW-1:0] c,
   output logic          cfg_done,
   output logic          cfg_err,
   output logic          cfg_loaded
);

   localparam int CNTW = $clog2(CW + 1);

   logic [CW-1:0]   shift_q;
   logic [CNTW-1:0] cnt;
   logic            cnt_full;
   cfg_state_e      state_q;
   cfg_state_e      state_d;
   logic            shift_acc;
   logic            commit_ok;
   logic            commit_bad;

   // A commit always wins the cycle, so a simultaneous shift is discarded.
   assign shift_acc  = cfg_en && !cfg_commit;
   assign commit_ok  = cfg_commit && (state_q == CFG_FULL) && cnt_full;
   assign commit_bad = cfg_commit && !commit_ok;

   cfg_bit_counter #(
      .MAX (CW)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (shift_acc),
      .clr   (commit_ok),
      .count (cnt),
      .full  (cnt_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else if (shift_acc) begin
         shift_q <= {shift_q[CW-2:0], cfg_in};
      end
   end

   // Pass-through comes straight from the register MSB, never from cfg_in.
   assign cfg_out = shift_q[CW-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CFG_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CFG_IDLE: begin
            if (shift_acc) begin
               state_d = CFG_SHIFT;
            end
         end
         CFG_SHIFT: begin
            if (shift_acc && (cnt == CNTW'(CW - 1))) begin
               state_d = CFG_FULL;
            end
         end
         CFG_FULL: begin
            state_d = CFG_FULL;
         end
         default: begin
            state_d = CFG_IDLE;
         end
      endcase
      if (commit_ok) begin
         state_d = CFG_IDLE;
      end
   end

   // The active frame only moves on a whole-frame commit, so the switch box
   // never sees bits that are still in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c          <= '0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
         cfg_loaded <= 1'b0;
      end else begin
         cfg_done <= commit_ok;
         if (commit_ok) begin
            c          <= shift_q;
            cfg_loaded <= 1'b1;
         end
         if (commit_bad) begin
            cfg_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Scoreboard bench for switch_box_config_loader: a bit-history reference model
// predicts every cycle's outputs and the frame each cfg_done should deliver.
module tb_switch_box_config_loader;

   localparam int W  = 8;
   localparam int CW = W * 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_en = 1'b0;
   logic          cfg_in = 1'b0;
   logic          cfg_commit = 1'b0;
   logic          cfg_out;
   logic [CW-1:0] c;
   logic          cfg_done;
   logic          cfg_err;
   logic          cfg_loaded;

   switch_box_config_loader #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_en     (cfg_en),
      .cfg_in     (cfg_in),
      .cfg_commit (cfg_commit),
      .cfg_out    (cfg_out),
      .c          (c),
      .cfg_done   (cfg_done),
      .cfg_err    (cfg_err),
      .cfg_loaded (cfg_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] c;
      logic          o;
      logic          d;
      logic          e;
      logic          l;
   } snap_t;

   snap_t         exp_q[$];
   logic [CW-1:0] done_q[$];

   // Reference model: the last CW bits shifted since reset, oldest first.
   bit            hist[$];
   int            mcount = 0;
   logic [CW-1:0] mc = '0;
   bit            mdone = 0;
   bit            merr = 0;
   bit            mloaded = 0;

   int total = 0;
   int bad   = 0;

   function automatic void chk(input string name, input logic [CW-1:0] act,
                               input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [CW-1:0] frame_of_hist();
      logic [CW-1:0] v = '0;
      for (int i = 0; i < CW; i++) v[CW-1-i] = hist[i];
      return v;
   endfunction

   task automatic step(input bit en, input bit din, input bit com, input bit rn);
      snap_t s;
      @(negedge clk);
      cfg_en = en; cfg_in = din; cfg_commit = com; rst_n = rn;
      mdone = 0;
      if (!rn) begin
         hist.delete();
         mcount = 0; mc = '0; merr = 0; mloaded = 0;
      end else if (com) begin
         if (mcount == CW) begin
            mc = frame_of_hist();
            mdone = 1; mloaded = 1; mcount = 0;
            done_q.push_back(mc);
         end else begin
            merr = 1;
         end
      end else if (en) begin
         hist.push_back(din);
         if (hist.size() > CW) void'(hist.pop_front());
         if (mcount < CW) mcount++;
      end
      s.c = mc;
      s.o = (hist.size() == CW) ? hist[0] : 1'b0;
      s.d = mdone; s.e = merr; s.l = mloaded;
      exp_q.push_back(s);
   endtask

   task automatic shift_word(input logic [CW-1:0] w);
      for (int i = CW - 1; i >= 0; i--) step(1, w[i], 0, 1);
   endtask

   task automatic shift_rand(input int n);
      for (int i = 0; i < n; i++) step(1, 1'($urandom), 0, 1);
   endtask

   // Monitor: compares whatever the DUT shows one step after each edge.
   initial begin
      snap_t s;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("c", c, s.c);
            chk("cfg_out", CW'(cfg_out), CW'(s.o));
            chk("cfg_done", CW'(cfg_done), CW'(s.d));
            chk("cfg_err", CW'(cfg_err), CW'(s.e));
            chk("cfg_loaded", CW'(cfg_loaded), CW'(s.l));
            if (cfg_done === 1'b1) begin
               if (done_q.size() == 0) begin
                  chk("unexpected_done", CW'(1), CW'(0));
               end else begin
                  chk("commit_frame", c, done_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CW-1:0] fa;
      logic [CW-1:0] fb;
      int            len;
      int            r;

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);

      shift_word(48'hA5A5_0F0F_C3C3);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      shift_rand(CW - 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
      shift_rand(1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);

      fa = {$urandom, $urandom};
      fb = {$urandom, $urandom};
      shift_word(fa);
      shift_word(fb);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);

      step(0, 0, 0, 0);
      shift_rand(CW);
      step(1, 1, 1, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);

      shift_rand(CW);
      step(0, 0, 1, 1);
      shift_rand(20);
      step(1, 1, 0, 0);
      step(0, 0, 0, 1);
      shift_rand(CW);
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);

      for (int f = 0; f < 40; f++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: len = CW;
            1: len = CW - 1;
            2: len = CW + $urandom_range(1, 20);
            default: len = $urandom_range(0, CW);
         endcase
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 7) == 0) step(0, 1'($urandom), 0, 1);
            step(1, 1'($urandom), 0, 1);
         end
         r = $urandom_range(0, 9);
         if (r == 0)      step(1'($urandom), 1'($urandom), 0, 0);
         else if (r == 1) step(1, 1'($urandom), 1, 1);
         else             step(0, 0, 1, 1);
         step(0, 0, 0, 1);
      end

      repeat (3) @(negedge clk);
      chk("pending_checks", CW'(exp_q.size()), CW'(0));
      chk("pending_commits", CW'(done_q.size()), CW'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/switch_box_config_loader.md
SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

Interface
REQ-001 SHALL have parameter W, default 8, meaning routing tracks per side of the downstream switch box.
REQ-002 SHALL have derived constant CW = W*6, meaning configuration bits delivered to the switch box.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port cfg_en  input  1  shift enable; one bitstream bit is accepted per cycle while high.
REQ-006 SHALL have port cfg_in  input  1  serial bitstream data.
REQ-007 SHALL have port cfg_commit  input  1  request to transfer the shift register to the active configuration.
REQ-008 SHALL have port cfg_out  output  1  serial pass-through to the next tile's loader.
REQ-009 SHALL have port c  output  CW  active configuration driving the switch box c input.
REQ-010 SHALL have port cfg_done  output  1  one-cycle pulse on a successful commit.
REQ-011 SHALL have port cfg_err  output  1  sticky flag for a commit on an incomplete frame.
REQ-012 SHALL have port cfg_loaded  output  1  high once any valid configuration has been committed.

Function
REQ-013 On cfg_en=1 and cfg_commit=0, the shift register SHALL update to {shift[CW-2:0], cfg_in}; the first bit shifted therefore ends at c[CW-1] after commit.
REQ-014 cfg_out SHALL equal shift[CW-1] (a flop output, no combinational path from cfg_in); cfg_in SHALL appear on cfg_out after exactly CW enabled shifts.
REQ-015 A bit counter SHALL increment once per accepted shift and saturate at CW; it SHALL not wrap.
REQ-016 The FSM SHALL have states IDLE (count=0), SHIFT (0<count<CW) and FULL (count=CW).
REQ-017 Transitions SHALL be IDLE->SHIFT on the first shift, SHIFT->FULL on the CW-th shift, FULL->FULL on further shifts (daisy-chain pass-through), and any state->IDLE on an accepted commit.
REQ-018 A commit in FULL SHALL load c from the shift register on that edge, pulse cfg_done high for exactly the following cycle, set cfg_loaded, and clear the counter; the shift register contents SHALL be retained.
REQ-019 A commit in IDLE or SHIFT SHALL leave c, the counter and the state unchanged and SHALL set cfg_err; cfg_err SHALL clear only on reset.
REQ-020 When cfg_commit and cfg_en are both high, the commit SHALL take priority and the shift SHALL be dropped; the counter SHALL clear, not increment.
REQ-021 c SHALL change only on an accepted commit or on reset; it SHALL never show a partially shifted frame.
REQ-022 With cfg_en=0 and cfg_commit=0, all state SHALL hold.

Reset
REQ-023 When rst_n=0 at a clock edge, the following SHALL be cleared: shift register, c, counter, cfg_out, cfg_done, cfg_err and cfg_loaded to 0, and the state to IDLE.
REQ-024 c=0 SHALL place every switch-box transmission element off, isolating all tracks.
REQ-025 Reset asserted mid-shift or in the commit cycle SHALL override every other input.

Structure
REQ-026 The constant CFG_BITS_PER_TRACK=6 and the FSM state enum SHALL live in the shared package fpga250_cfg_pkg.
REQ-027 The saturating counter SHALL be the single sub-module cfg_bit_counter, with parameter MAX=CW and ports clk, rst_n, inc, clr, count, full.
REQ-028 The shift register, FSM and active register SHALL be inline in switch_box_config_loader.

Verification
REQ-029 Reset (W=8): hold rst_n=0 for 2 cycles -> c=48'h0, cfg_out=0, cfg_done=0, cfg_err=0, cfg_loaded=0.
REQ-030 Full load: shift 48 bits of 48'hA5A5_0F0F_C3C3 MSB first, then commit -> c=48'hA5A5_0F0F_C3C3, a single-cycle cfg_done, cfg_loaded=1.
REQ-031 Short frame: shift 47 bits, then commit -> cfg_err=1, c unchanged, no cfg_done; 1 more shift + commit -> load succeeds and cfg_err stays 1.
REQ-032 Daisy-chain: shift 96 bits (frame A then frame B) -> bits 49..96 on cfg_out reproduce frame A in order; commit -> c=frame B.
REQ-033 Collision: after 48 shifts, assert cfg_en=1 and cfg_commit=1 with cfg_in=1 -> c=the 48 pre-collision bits, counter=0, state=IDLE.
REQ-034 Mid-operation reset: pulse rst_n=0 after 20 shifts following a prior load -> c=0, state=IDLE; a later 48-bit load completes normally.
